// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in serial-out transmitter. A WIDTH-bit word is accepted over a
// valid/ready handshake and shifted out one bit per clock. Bit order is set by
// MSB_FIRST. The next word can be accepted during the last-bit cycle, so words
// stream back to back with no idle gap.
//
// Parameters:
//   WIDTH      word width in bits (2..32)
//   MSB_FIRST  1 = bit WIDTH-1 first, 0 = bit 0 first
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous, active-high reset
//   load_valid    load_data is valid this cycle
//   load_data     word to serialize
//   load_ready    a word can be accepted this cycle
//   serial_out    current serial bit (0 when idle)
//   serial_valid  serial_out carries a data bit
//   serial_last   current bit is the final bit of the word
//   busy          word in flight (same as serial_valid)
//
// State table:
//   state | meaning
//   IDLE  | no word in flight, ready to accept
//   SHIFT | driving a word; counter = bits remaining after the current one
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             serial_last,
  output logic             busy
);

  localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic in_shift;
  logic cnt_zero;
  logic accept;

  assign in_shift = (state_q == SHIFT);
  assign cnt_zero = (cnt_q == '0);

  // Ready in IDLE and during the final bit so the next word follows directly.
  assign load_ready = !in_shift || cnt_zero;
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = load_data;
          cnt_d   = CNT_MAX;
        end
      end
      SHIFT: begin
        if (!cnt_zero) begin
          if (MSB_FIRST) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          end else begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - 1'b1;
        end else if (load_valid) begin
          // Last bit with a new word waiting: reload, stay in SHIFT.
          shreg_d = load_data;
          cnt_d   = CNT_MAX;
        end else begin
          state_d = IDLE;
          shreg_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  logic tx_bit;
  assign tx_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  // Outputs are derived from registers only, so reset clears them immediately.
  assign serial_out   = in_shift && tx_bit;
  assign serial_valid = in_shift;
  assign serial_last  = in_shift && cnt_zero;
  assign busy         = in_shift;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Bench for piso_serializer. Two instances: 4-bit MSB-first and 8-bit
// LSB-first. The reference model keeps a queue of expected (bit, last) pairs
// per instance; accepting a word appends its bits in transmit order, each clock
// pops one. A 4-bit shift-left SIPO is attached to the 4-bit instance.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  logic clk;
  logic reset;

  logic       load_valid4, load_ready4, serial_out4, serial_valid4, serial_last4, busy4;
  logic [3:0] load_data4;
  logic       load_valid8, load_ready8, serial_out8, serial_valid8, serial_last8, busy8;
  logic [7:0] load_data8;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut4 (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid4),
    .load_data    (load_data4),
    .load_ready   (load_ready4),
    .serial_out   (serial_out4),
    .serial_valid (serial_valid4),
    .serial_last  (serial_last4),
    .busy         (busy4)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid8),
    .load_data    (load_data8),
    .load_ready   (load_ready8),
    .serial_out   (serial_out8),
    .serial_valid (serial_valid8),
    .serial_last  (serial_last8),
    .busy         (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic l;
  } ebit_t;

  ebit_t q4[$];
  ebit_t q8[$];
  logic [3:0] sipo4;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Append a word's bits in transmit order.
  task automatic push_word(inout ebit_t q[$], input logic [31:0] word, input int w, input bit msb_first);
    ebit_t e;
    for (int i = 0; i < w; i++) begin
      e.b = msb_first ? word[w-1-i] : word[i];
      e.l = (i == w - 1);
      q.push_back(e);
    end
  endtask

  task automatic check_outputs();
    if (q4.size() > 0) begin
      chk("w4_valid", serial_valid4, 1);
      chk("w4_busy",  busy4, 1);
      chk("w4_out",   serial_out4, q4[0].b);
      chk("w4_last",  serial_last4, q4[0].l);
      chk("w4_ready", load_ready4, q4[0].l);
    end else begin
      chk("w4_idle_valid", serial_valid4, 0);
      chk("w4_idle_busy",  busy4, 0);
      chk("w4_idle_out",   serial_out4, 0);
      chk("w4_idle_last",  serial_last4, 0);
      chk("w4_idle_ready", load_ready4, 1);
    end
    if (q8.size() > 0) begin
      chk("w8_valid", serial_valid8, 1);
      chk("w8_busy",  busy8, 1);
      chk("w8_out",   serial_out8, q8[0].b);
      chk("w8_last",  serial_last8, q8[0].l);
      chk("w8_ready", load_ready8, q8[0].l);
    end else begin
      chk("w8_idle_valid", serial_valid8, 0);
      chk("w8_idle_busy",  busy8, 0);
      chk("w8_idle_out",   serial_out8, 0);
      chk("w8_idle_last",  serial_last8, 0);
      chk("w8_idle_ready", load_ready8, 1);
    end
  endtask

  // Called just after a falling edge: check, drive, clock, update model.
  task automatic step(input logic lv4, input logic [3:0] ld4, input logic lv8, input logic [7:0] ld8);
    logic rdy4, rdy8, sv4, so4;
    check_outputs();
    rdy4 = (q4.size() == 0) || q4[0].l;
    rdy8 = (q8.size() == 0) || q8[0].l;
    sv4  = serial_valid4;
    so4  = serial_out4;
    load_valid4 = lv4;
    load_data4  = ld4;
    load_valid8 = lv8;
    load_data8  = ld8;
    @(posedge clk);
    if (reset) begin
      q4.delete();
      q8.delete();
    end else begin
      if (q4.size() > 0) void'(q4.pop_front());
      if (q8.size() > 0) void'(q8.pop_front());
      if (lv4 && rdy4) push_word(q4, {28'd0, ld4}, 4, 1'b1);
      if (lv8 && rdy8) push_word(q8, {24'd0, ld8}, 8, 1'b0);
    end
    if (sv4) sipo4 = {sipo4[2:0], so4};
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 8'h00);
  endtask

  initial begin
    reset       = 1'b1;
    load_valid4 = 1'b1;
    load_data4  = 4'hF;
    load_valid8 = 1'b1;
    load_data8  = 8'hFF;
    sipo4       = 4'h0;

    // Reset state, with load_valid high and ignored.
    @(negedge clk);
    check_outputs();
    step(1'b1, 4'hF, 1'b1, 8'hFF);
    step(1'b1, 4'hF, 1'b1, 8'hFF);
    reset = 1'b0;
    idle_steps(2);

    // Single word 1011, checked against an attached SIPO.
    sipo4 = 4'h0;
    step(1'b1, 4'hB, 1'b0, 8'h00);
    idle_steps(4);
    chk("sipo_1011", sipo4, 4'b1011);
    idle_steps(2);

    // Back-to-back A then 5 with load_valid held.
    step(1'b1, 4'hA, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b1, 4'h5, 1'b0, 8'h00);
    idle_steps(4);
    chk("sipo_b2b", sipo4, 4'h5);
    idle_steps(1);

    // Backpressure: F requested from bit 2 of word 3.
    step(1'b1, 4'h3, 1'b0, 8'h00);
    step(1'b0, 4'h0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 1'b0, 8'h00);
    idle_steps(5);

    // Asynchronous reset mid-word after two bits of C.
    step(1'b1, 4'hC, 1'b0, 8'h00);
    idle_steps(2);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", serial_valid4, 0);
    chk("arst_out",   serial_out4, 0);
    chk("arst_busy",  busy4, 0);
    chk("arst_last",  serial_last4, 0);
    chk("arst_ready", load_ready4, 1);
    q4.delete();
    q8.delete();
    @(negedge clk);
    step(1'b1, 4'h9, 1'b0, 8'h00);
    reset = 1'b0;
    idle_steps(1);
    sipo4 = 4'h0;
    step(1'b1, 4'h6, 1'b0, 8'h00);
    idle_steps(4);
    chk("sipo_after_rst", sipo4, 4'h6);

    // LSB-first 8-bit: 81 then 02 queued.
    step(1'b0, 4'h0, 1'b1, 8'h81);
    for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 1'b1, 8'h02);
    idle_steps(9);

    // load_data changes right after accept.
    sipo4 = 4'h0;
    step(1'b1, 4'hD, 1'b1, 8'hA5);
    step(1'b0, 4'h2, 1'b0, 8'h3C);
    idle_steps(4);
    chk("sipo_sampled", sipo4, 4'hD);
    idle_steps(6);

    // Randomized traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
    end
    idle_steps(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per clock, with a serial valid qualifier and a last-bit flag. It feeds a shift-left, LSB-in SIPO deserializer. With MSB_FIRST=1, after WIDTH valid bits the deserializer register holds the original word unchanged. Back-to-back words stream with no idle gap.

Parameters:
WIDTH, 4, word width in bits (legal: 2..32)
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
load_valid  input  1  load_data is valid this cycle
load_data  input  WIDTH  word to serialize
load_ready  output  1  block can accept a word this cycle
serial_out  output  1  current serial bit
serial_valid  output  1  serial_out carries a data bit this cycle
serial_last  output  1  current bit is the final bit of the word
busy  output  1  word in flight (equals serial_valid)

Behaviour:
- Async reset (reset=1), regardless of clk:
  - state=IDLE, shift register=0, bit counter=0.
  - Outputs: serial_out=0, serial_valid=0, serial_last=0, busy=0, load_ready=1.
  - load_valid is ignored while reset is high.
- State machine, 2 states:
  - IDLE -> SHIFT on load_valid&&load_ready.
  - SHIFT -> IDLE after the last bit when no new word is accepted.
  - SHIFT -> SHIFT on the last bit when a new word is accepted.
- Accept on a rising edge with load_valid&&load_ready:
  - shift register <= load_data.
  - counter <= WIDTH-1.
  - state <= SHIFT.
  - load_data is sampled only on that edge; later changes have no effect.
- Latency: the first bit appears on serial_out in the cycle after the accept edge. A word occupies exactly WIDTH consecutive serial_valid cycles.
- In SHIFT, outputs are combinational from registers:
  - serial_out = shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
  - serial_valid = 1, busy = 1.
  - serial_last = (counter==0).
- Each SHIFT edge with counter!=0:
  - MSB_FIRST: shreg <= shreg<<1, zero filled at LSB.
  - LSB_FIRST: shreg <= shreg>>1, zero filled at MSB.
  - counter <= counter-1.
- load_ready = (state==IDLE) || (state==SHIFT && counter==0). The block accepts the next word during the last-bit cycle.
- Last-bit edge (SHIFT, counter==0):
  - If load_valid: reload the shift register and counter, stay in SHIFT. The next word's first bit follows immediately, with zero gap.
  - Else: state <= IDLE, shreg <= 0.
- In IDLE: serial_out=0, serial_valid=0, serial_last=0, busy=0.
- load_valid while load_ready=0 (mid-word) is ignored. The upstream must hold load_valid and load_data until a ready cycle. The in-flight word is never corrupted.
- Reset mid-word aborts the word immediately. Outputs go to reset values asynchronously. No partial word resumes after reset deasserts.
- Counter width is clog2(WIDTH), minimum 1 bit. It never wraps below 0.

Test Plan:
1. Reset, then load 4'b1011 with load_valid for 1 cycle in IDLE -> from the next cycle serial_out=1,0,1,1 with serial_valid=1 for 4 cycles and serial_last=1 on the 4th only. Then IDLE, serial_out=0. An attached 4-bit SIPO reads 4'b1011.
2. Back-to-back: 4'hA accepted, load_valid held with 4'h5 -> load_ready=1 only in the 4th bit cycle. 8 contiguous valid bits 1,0,1,0,0,1,0,1 with no gap.
3. Backpressure: assert load_valid=1 with 4'hF during bit 2 of word 4'h3 -> ignored until the last-bit cycle. Output 0,0,1,1 then 1,1,1,1.
4. Reset asserted asynchronously mid-word (after 2 bits of 4'hC) -> serial_valid, serial_out and busy drop to 0 without a clock edge. After release, load 4'h6 -> clean 0,1,1,0.
5. MSB_FIRST=0, WIDTH=8, load 8'h81 then 8'h02 -> bits 1,0,0,0,0,0,0,1 then 0,1,0,0,0,0,0,0. serial_last on bits 8 and 16.
6. load_data changed on the cycle after accept -> serialized value equals the value sampled at the accept edge.
